// File: rtl/pwm_multi_if.sv
// Peripheral-side Wishbone bundle: one clock, sync reset, single-beat strobe/ack
// handshake with 16-bit data in each direction.
interface iWishbone #(
  parameter int pAdrBits = 8
);
  logic                clk;
  logic                rst;
  logic                stb;
  logic                we;
  logic [pAdrBits-1:0] adr;
  logic [15:0]         dat_c;
  logic [15:0]         dat_p;
  logic                ack;

  modport mPeri (input clk, rst, stb, we, adr, dat_c, output dat_p, ack);
  modport mCtrl (input clk, rst, dat_p, ack, output stb, we, adr, dat_c);
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel Wishbone PWM: double-buffered duty, per-channel polarity, edge- or
// center-aligned counter, period counter; ack one cycle after stb, outputs registered.
module pwm_multi #(
  parameter int pWbHz     = 0,
  parameter int pOutHz    = 0,
  parameter int pChannels = 4,
  parameter int pBits     = 8
) (
  iWishbone.mPeri              wb,
  output logic [pChannels-1:0] pwm
);

  localparam longint lpMax = (longint'(1) << pBits) - 1;

  function automatic int calc_ticks();
    longint den;
    longint t;
    den = longint'(pOutHz) * lpMax;
    if (den <= 0) return 1;
    t = longint'(pWbHz) / den;
    return (t < 1) ? 1 : int'(t);
  endfunction

  localparam int               lpTicks  = calc_ticks();
  localparam int               lpPw     = (lpTicks > 1) ? $clog2(lpTicks) : 1;
  localparam logic [lpPw-1:0]  lpPreTop = lpPw'(lpTicks - 1);
  localparam logic [pBits-1:0] lpCntTop = pBits'(lpMax - 1);

  logic                            ack_q, ack_d;
  logic [15:0]                     dat_p_q, dat_p_d;
  logic                            en_q, en_d;
  logic                            center_q, center_d;
  logic                            mode_q;
  logic [pChannels-1:0]            pol_q, pol_d;
  logic [pChannels-1:0]            pwm_q, pwm_d;
  logic [pChannels-1:0][pBits-1:0] shadow_q, shadow_d;
  logic [pChannels-1:0][pBits-1:0] active_q;
  logic [pBits-1:0]                cnt_q;
  logic                            down_q;
  logic [lpPw-1:0]                 presc_q;
  logic [15:0]                     periods_q;

  logic [31:0] adr_u;
  logic        wr, rd;
  logic        tick, boundary, reload;
  logic [15:0] rdata;
  logic        unused_dat;

  assign adr_u      = 32'(wb.adr);
  assign unused_dat = ^wb.dat_c;

  // Writes use next-state values so a write landing on a boundary loads straight into active.
  always_comb begin
    wr       = wb.stb & wb.we & ~ack_q;
    rd       = wb.stb & ~wb.we & ~ack_q;
    ack_d    = wb.stb & ~ack_q;
    shadow_d = shadow_q;
    en_d     = en_q;
    center_d = center_q;
    pol_d    = pol_q;
    rdata    = '0;
    for (int n = 0; n < pChannels; n++) begin
      if (adr_u == 32'(n)) begin
        rdata = 16'(shadow_q[n]);
        if (wr) shadow_d[n] = wb.dat_c[pBits-1:0];
      end
    end
    if (adr_u == 32'(pChannels)) begin
      rdata = {14'd0, center_q, en_q};
      if (wr) begin
        en_d     = wb.dat_c[0];
        center_d = wb.dat_c[1];
      end
    end
    if (adr_u == 32'(pChannels + 1)) begin
      rdata = 16'(pol_q);
      if (wr) pol_d = wb.dat_c[pChannels-1:0];
    end
    if (adr_u == 32'(pChannels + 2)) rdata = periods_q;
    dat_p_d = rd ? rdata : 16'd0;
  end

  assign tick     = en_q && (presc_q == lpPreTop);
  assign boundary = tick && (mode_q ? (down_q && (cnt_q == '0)) : (cnt_q == lpCntTop));
  assign reload   = !en_q || boundary;

  always_comb begin
    pwm_d = pol_q;
    for (int n = 0; n < pChannels; n++) begin
      if (en_q) pwm_d[n] = (cnt_q < active_q[n]) ^ pol_q[n];
    end
  end

  always_ff @(posedge wb.clk) begin
    if (wb.rst) begin
      ack_q     <= 1'b0;
      dat_p_q   <= '0;
      en_q      <= 1'b0;
      center_q  <= 1'b0;
      mode_q    <= 1'b0;
      pol_q     <= '0;
      pwm_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      cnt_q     <= '0;
      down_q    <= 1'b0;
      presc_q   <= '0;
      periods_q <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_p_q  <= dat_p_d;
      en_q     <= en_d;
      center_q <= center_d;
      pol_q    <= pol_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
      if (reload) begin
        active_q <= shadow_d;
        mode_q   <= center_d;
      end
      if (boundary) periods_q <= periods_q + 16'd1;
      if (!en_q) begin
        presc_q <= '0;
        cnt_q   <= '0;
        down_q  <= 1'b0;
      end else if (!tick) begin
        presc_q <= presc_q + lpPw'(1);
      end else begin
        presc_q <= '0;
        // Center mode dwells one tick at each extreme while the direction flips.
        if (boundary) begin
          cnt_q  <= '0;
          down_q <= 1'b0;
        end else if (!mode_q) begin
          cnt_q <= cnt_q + pBits'(1);
        end else if (!down_q) begin
          if (cnt_q == lpCntTop) down_q <= 1'b1;
          else cnt_q <= cnt_q + pBits'(1);
        end else begin
          cnt_q <= cnt_q - pBits'(1);
        end
      end
    end
  end

  assign wb.ack   = ack_q;
  assign wb.dat_p = dat_p_q;
  assign pwm      = pwm_q;

endmodule
